// File: rtl/teta_update.sv
`timescale 1ns/1ps
// teta_update: one gradient step on a weight vector, one element per cycle.
// teta[i] -= ((h - y) * x[i]) >>> LR_SHIFT, saturated to the element range.
module teta_update #(
    parameter int NUM_ELEMS  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LR_SHIFT   = 3,
    parameter int IDX_W      = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [0:NUM_ELEMS*DATA_WIDTH-1]   x,
    input  logic [0:NUM_ELEMS*DATA_WIDTH-1]   teta,
    input  logic [DATA_WIDTH-1:0]             h,
    input  logic [DATA_WIDTH-1:0]             y,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [0:NUM_ELEMS*DATA_WIDTH-1]   teta_out,
    output logic                              sat_flag
);

    localparam int EW = DATA_WIDTH + 1;
    localparam int PW = EW + DATA_WIDTH;
    localparam int NW = PW + 1;

    localparam logic signed [NW-1:0] MAXV = NW'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [NW-1:0] MINV = ~MAXV;
    localparam logic [IDX_W-1:0]     LAST = IDX_W'(NUM_ELEMS - 1);

    typedef logic signed [DATA_WIDTH-1:0] elem_t;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic signed [EW-1:0]  err_q;
    elem_t                 x_q    [NUM_ELEMS];
    elem_t                 teta_q [NUM_ELEMS];
    elem_t                 tout_q [NUM_ELEMS];
    logic                  out_valid_q;
    logic                  sat_q;

    elem_t                 x_cur;
    elem_t                 t_cur;
    logic signed [EW-1:0]  err_d;
    logic signed [PW-1:0]  prod;
    logic signed [PW-1:0]  delta;
    logic signed [NW-1:0]  newv;
    elem_t                 new_e;
    logic                  sat;

    assign x_cur = x_q[idx_q];
    assign t_cur = teta_q[idx_q];
    assign err_d = EW'($signed(h)) - EW'($signed(y));

    // Widths are chosen so the product and difference can never wrap.
    always_comb begin
        prod  = PW'(err_q) * PW'(x_cur);
        delta = prod >>> LR_SHIFT;
        newv  = NW'(t_cur) - NW'(delta);
        sat   = 1'b0;
        new_e = DATA_WIDTH'(newv);
        if (newv > MAXV) begin
            sat   = 1'b1;
            new_e = DATA_WIDTH'(MAXV);
        end else if (newv < MINV) begin
            sat   = 1'b1;
            new_e = DATA_WIDTH'(MINV);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            err_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            for (int i = 0; i < NUM_ELEMS; i++) begin
                x_q[i]    <= '0;
                teta_q[i] <= '0;
                tout_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < NUM_ELEMS; i++) begin
                            x_q[i]    <= x[i*DATA_WIDTH +: DATA_WIDTH];
                            teta_q[i] <= teta[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        err_q   <= err_d;
                        sat_q   <= 1'b0;
                        idx_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (enable) begin
                        tout_q[idx_q] <= new_e;
                        sat_q         <= sat_q | sat;
                        idx_q         <= idx_q + 1'b1;
                        if (idx_q == LAST) begin
                            idx_q       <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sat_flag  = sat_q;

    for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_pack
        assign teta_out[g*DATA_WIDTH +: DATA_WIDTH] = tout_q[g];
    end

endmodule

// File: tb/tb_teta_update.sv
`timescale 1ns/1ps
// Self-checking bench for teta_update: directed scenarios plus random
// samples compared against an arithmetic model of the weight update.
module tb_teta_update;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [0:63] x = '0;
    logic [0:63] teta = '0;
    logic [7:0]  h = '0;
    logic [7:0]  y = '0;
    logic        in_ready;
    logic        out_valid;
    logic [0:63] teta_out;
    logic        sat_flag;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    teta_update dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .teta(teta), .h(h), .y(y),
        .out_valid(out_valid), .out_ready(out_ready),
        .teta_out(teta_out), .sat_flag(sat_flag)
    );

    function automatic logic [0:63] fill(input logic [7:0] v);
        logic [0:63] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = v;
        return r;
    endfunction

    // Floor division by the learning-rate divisor, then clamp.
    function automatic void model(input logic [0:63] xv, input logic [0:63] tv,
                                  input logic [7:0] hv, input logic [7:0] yv,
                                  output logic [0:63] r, output logic s);
        int err, xi, ti, p, d, nv;
        err = int'($signed(hv)) - int'($signed(yv));
        s = 1'b0;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            xi = int'($signed(xv[8*i +: 8]));
            ti = int'($signed(tv[8*i +: 8]));
            p = err * xi;
            if (p >= 0) d = p / 8;
            else d = -((-p + 7) / 8);
            nv = ti - d;
            if (nv > 127) begin nv = 127; s = 1'b1; end
            else if (nv < -128) begin nv = -128; s = 1'b1; end
            r[8*i +: 8] = 8'(nv);
        end
    endfunction

    task automatic start(input logic [0:63] xv, input logic [0:63] tv,
                         input logic [7:0] hv, input logic [7:0] yv);
        @(negedge clk);
        x = xv; teta = tv; h = hv; y = yv; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x = {$urandom, $urandom};
        teta = {$urandom, $urandom};
        h = 8'($urandom);
        y = 8'($urandom);
    endtask

    // Enable is dropped before edges ss .. ss+sl-1 counted from the accept.
    task automatic wait_done(input int ss, input int sl, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            enable = !((lat + 1 >= ss) && (lat + 1 < ss + sl));
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        enable = 1'b1;
    endtask

    task automatic handshake(input int hold);
        out_ready = 1'b0;
        repeat (hold) begin @(posedge clk); @(negedge clk); end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #3 reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++;
        if (teta_out !== 64'h0) begin bad++; $display("FAIL reset_teta_out got=%h exp=0", teta_out); end
        total++;
        if (sat_flag !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", sat_flag); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic;
        logic [0:63] e; logic s; int lat;
        model(fill(8'd2), fill(8'd4), 8'd10, 8'd2, e, s);
        total++;
        if (e !== fill(8'd2)) begin bad++; $display("FAIL basic_model got=%h exp=%h", e, fill(8'd2)); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
        start(fill(8'd2), fill(8'd4), 8'd10, 8'd2);
        wait_done(0, 0, lat);
        total++;
        if (lat !== 8) begin bad++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        total++;
        if (teta_out !== e) begin bad++; $display("FAIL basic_teta_out got=%h exp=%h", teta_out, e); end
        total++;
        if (sat_flag !== s) begin bad++; $display("FAIL basic_sat got=%b exp=%b", sat_flag, s); end
        handshake(0);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_accept got=%b exp=0", out_valid); end
    endtask

    task automatic test_saturate;
        logic [0:63] e; logic s; int lat;
        model(fill(8'h7F), fill(8'h80), 8'h7F, 8'h80, e, s);
        start(fill(8'h7F), fill(8'h80), 8'h7F, 8'h80);
        wait_done(0, 0, lat);
        total++;
        if (lat !== 8) begin bad++; $display("FAIL sat_latency got=%0d exp=8", lat); end
        total++;
        if (teta_out !== fill(8'h80)) begin bad++; $display("FAIL sat_teta_out got=%h exp=%h", teta_out, fill(8'h80)); end
        total++;
        if (sat_flag !== 1'b1 || s !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b exp=1", sat_flag); end
        handshake(0);
    endtask

    task automatic test_floor;
        logic [0:63] e; logic s; int lat;
        model(fill(8'd1), fill(8'd5), 8'd0, 8'd1, e, s);
        start(fill(8'd1), fill(8'd5), 8'd0, 8'd1);
        wait_done(0, 0, lat);
        total++;
        if (teta_out !== fill(8'd6) || e !== fill(8'd6)) begin bad++; $display("FAIL floor_teta_out got=%h exp=%h", teta_out, fill(8'd6)); end
        total++;
        if (sat_flag !== 1'b0) begin bad++; $display("FAIL floor_sat got=%b exp=0", sat_flag); end
        handshake(0);
    endtask

    task automatic test_stall;
        logic [0:63] xv, tv, e; logic s; int lat;
        xv = 64'h0102_F3FC_7F80_1A9B;
        tv = 64'h10E0_7F80_0040_C0FF;
        model(xv, tv, 8'd37, 8'hF0, e, s);
        start(xv, tv, 8'd37, 8'hF0);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready_calc got=%b exp=0", in_ready); end
        wait_done(4, 3, lat);
        total++;
        if (lat !== 11) begin bad++; $display("FAIL stall_latency got=%0d exp=11", lat); end
        total++;
        if (teta_out !== e) begin bad++; $display("FAIL stall_teta_out got=%h exp=%h", teta_out, e); end
        total++;
        if (sat_flag !== s) begin bad++; $display("FAIL stall_sat got=%b exp=%b", sat_flag, s); end
        handshake(0);
    endtask

    task automatic test_back_to_back;
        logic [0:63] ea, eb; logic sa, sb; int lat;
        model(fill(8'd3), fill(8'd10), 8'd5, 8'd1, ea, sa);
        model(fill(8'd1), fill(8'd5), 8'd0, 8'd1, eb, sb);
        start(fill(8'd3), fill(8'd10), 8'd5, 8'd1);
        wait_done(0, 0, lat);
        x = fill(8'd1); teta = fill(8'd5); h = 8'd0; y = 8'd1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || teta_out !== ea || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d got v=%b r=%b t=%h exp v=1 r=0 t=%h", k, out_valid, in_ready, teta_out, ea);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL handshake got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(0, 0, lat);
        total++;
        if (lat !== 8) begin bad++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
        total++;
        if (teta_out !== eb || sat_flag !== sb) begin bad++; $display("FAIL b2b_teta_out got=%h exp=%h", teta_out, eb); end
        handshake(0);
    endtask

    task automatic test_reset_mid;
        logic [0:63] e; logic s; int lat;
        start(fill(8'h7F), fill(8'h80), 8'h7F, 8'h80);
        repeat (4) begin @(posedge clk); @(negedge clk); end
        #2 reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sat_flag !== 1'b0 || teta_out !== 64'h0) begin
            bad++;
            $display("FAIL reset_mid got r=%b v=%b s=%b t=%h exp r=1 v=0 s=0 t=0", in_ready, out_valid, sat_flag, teta_out);
        end
        @(negedge clk);
        reset = 1'b1;
        model(fill(8'd2), fill(8'd4), 8'd10, 8'd2, e, s);
        start(fill(8'd2), fill(8'd4), 8'd10, 8'd2);
        wait_done(0, 0, lat);
        total++;
        if (lat !== 8 || teta_out !== e || sat_flag !== s) begin
            bad++;
            $display("FAIL after_reset got lat=%0d t=%h s=%b exp lat=8 t=%h s=%b", lat, teta_out, sat_flag, e, s);
        end
        handshake(0);
    endtask

    task automatic test_random;
        logic [0:63] xv, tv, e; logic s; logic [7:0] hv, yv;
        int lat, ss, sl;
        for (int n = 0; n < 40; n++) begin
            xv = {$urandom, $urandom};
            tv = {$urandom, $urandom};
            hv = 8'($urandom);
            yv = 8'($urandom);
            if (n % 5 == 0) hv = yv;
            ss = $urandom_range(1, 8);
            sl = $urandom_range(0, 3);
            model(xv, tv, hv, yv, e, s);
            start(xv, tv, hv, yv);
            wait_done(ss, sl, lat);
            total++;
            if (lat !== 8 + sl || teta_out !== e || sat_flag !== s) begin
                bad++;
                $display("FAIL rand_%0d got lat=%0d t=%h s=%b exp lat=%0d t=%h s=%b", n, lat, teta_out, sat_flag, 8 + sl, e, s);
            end
            handshake($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_floor();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
